rip_lsu: RTL

Load/store unit that consumes the address computed by the execute-stage ALU and carries out the data-memory transaction for RV32I LB/LH/LW/LBU/LHU/SB/SH/SW. It handles byte-lane steering, store-data replication, load extraction with sign/zero extension, misalignment/illegal-op detection, a bus timeout, and pipeline flush with response draining. It sits between execute and writeback, and is the single master on the data-memory request/response port.

---
 rtl/rip_lsu.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/rip_lsu.sv
`default_nettype none
// ============================================================================
// Module   : rip_lsu
// Brief    : RV32I load/store unit. Steers byte lanes, replicates store data,
//            extracts and extends load data, detects misaligned and illegal
//            operations, aborts on a bus timeout and drains flushed loads.
// Revision : 1.0 - initial release
// ============================================================================
module rip_lsu #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        flush,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  resp_cause
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] c_CAUSE_NONE = 2'd0;
    localparam logic [1:0] c_CAUSE_MIS  = 2'd1;
    localparam logic [1:0] c_CAUSE_ILL  = 2'd2;
    localparam logic [1:0] c_CAUSE_TMO  = 2'd3;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_store;
    logic [2:0]         r_funct3;
    logic [31:0]        r_addr;
    logic [3:0]         r_be;
    logic [31:0]        r_wdata;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_resp_rdata;
    logic               r_resp_err;
    logic [1:0]         r_resp_cause;

    logic               w_accept;
    logic               w_illegal;
    logic               w_misaligned;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata_rep;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_timeout;
    logic [31:0]        w_shift;
    logic [31:0]        w_load_data;
    logic               w_set_resp;
    logic [31:0]        w_resp_rdata_nxt;
    logic               w_resp_err_nxt;
    logic [1:0]         w_resp_cause_nxt;

    // A flush in the same cycle blocks acceptance; req_ready itself stays a pure state decode.
    assign w_accept  = req_valid && (r_state == S_IDLE) && !flush;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    // Fires on the cycle that completes TIMEOUT_CYCLES counted cycles.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc >= CNT_W'(TIMEOUT_CYCLES));
    assign w_shift   = mem_rdata >> {r_addr[1:0], 3'b000};

    // Decode illegal/misaligned conditions, byte enables and replicated store data of the offered op.
    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        w_be         = 4'b1111;
        w_wdata_rep  = req_wdata;
        if (req_store) begin
            w_illegal = (req_funct3 >= 3'd3);
        end else begin
            w_illegal = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7);
        end
        case (req_funct3[1:0])
            2'b00: begin
                w_be        = 4'b0001 << req_addr[1:0];
                w_wdata_rep = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be         = 4'b0011 << req_addr[1:0];
                w_wdata_rep  = {2{req_wdata[15:0]}};
                w_misaligned = req_addr[0];
            end
            default: begin
                w_be         = 4'b1111;
                w_wdata_rep  = req_wdata;
                w_misaligned = (req_addr[1:0] != 2'b00);
            end
        endcase
    end

    // Extract the addressed lane from the read word and sign/zero extend it.
    always_comb begin
        w_load_data = w_shift;
        case (r_funct3)
            3'd0:    w_load_data = {{24{w_shift[7]}}, w_shift[7:0]};
            3'd1:    w_load_data = {{16{w_shift[15]}}, w_shift[15:0]};
            3'd4:    w_load_data = {24'd0, w_shift[7:0]};
            3'd5:    w_load_data = {16'd0, w_shift[15:0]};
            default: w_load_data = w_shift;
        endcase
    end

    // Next-state and response capture; flush outranks gnt, rvalid and timeout.
    always_comb begin
        w_state_nxt      = r_state;
        w_set_resp       = 1'b0;
        w_resp_rdata_nxt = 32'd0;
        w_resp_err_nxt   = 1'b0;
        w_resp_cause_nxt = c_CAUSE_NONE;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_illegal || w_misaligned) begin
                        w_state_nxt      = S_DONE;
                        w_set_resp       = 1'b1;
                        w_resp_err_nxt   = 1'b1;
                        w_resp_cause_nxt = w_illegal ? c_CAUSE_ILL : c_CAUSE_MIS;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (flush) begin
                    // A granted load still owes a read beat that must be swallowed.
                    w_state_nxt = (mem_gnt && !r_store) ? S_DRAIN : S_IDLE;
                end else if (mem_gnt) begin
                    if (r_store) begin
                        w_state_nxt = S_DONE;
                        w_set_resp  = 1'b1;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end else if (w_timeout) begin
                    w_state_nxt      = S_DONE;
                    w_set_resp       = 1'b1;
                    w_resp_err_nxt   = 1'b1;
                    w_resp_cause_nxt = c_CAUSE_TMO;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    // If the beat lands with the flush it is discarded here; nothing left to drain.
                    w_state_nxt = mem_rvalid ? S_IDLE : S_DRAIN;
                end else if (mem_rvalid) begin
                    w_state_nxt      = S_DONE;
                    w_set_resp       = 1'b1;
                    w_resp_rdata_nxt = w_load_data;
                end else if (w_timeout) begin
                    w_state_nxt      = S_DONE;
                    w_set_resp       = 1'b1;
                    w_resp_err_nxt   = 1'b1;
                    w_resp_cause_nxt = c_CAUSE_TMO;
                end
            end
            S_DRAIN: begin
                if (mem_rvalid || w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture the accepted operation; these fields drive the memory port while in REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_store  <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_be     <= 4'd0;
            r_wdata  <= 32'd0;
        end else if (w_accept) begin
            r_store  <= req_store;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_be     <= w_be;
            r_wdata  <= w_wdata_rep;
        end
    end

    // Timeout counter: idle clears it, so it starts from zero on every entry to REQ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= '0;
        end else if ((r_state == S_REQ) || (r_state == S_WAIT) || (r_state == S_DRAIN)) begin
            r_cnt <= w_cnt_inc;
        end
    end

    // Response fields update only when entering DONE and hold until the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
            r_resp_cause <= 2'd0;
        end else if (w_set_resp) begin
            r_resp_rdata <= w_resp_rdata_nxt;
            r_resp_err   <= w_resp_err_nxt;
            r_resp_cause <= w_resp_cause_nxt;
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign mem_req    = (r_state == S_REQ);
    assign mem_we     = r_store;
    assign mem_addr   = {r_addr[31:2], 2'b00};
    assign mem_be     = r_be;
    assign mem_wdata  = r_wdata;
    // A flush during DONE suppresses the completion pulse.
    assign resp_valid = (r_state == S_DONE) && !flush;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign resp_cause = r_resp_cause;

endmodule
`default_nettype wire
